// File: rtl/sd2_ovf_serial.sv
// Digit-serial SD2 sign/overflow resolver: takes a flag digit plus NDIG digits MSD-first and streams |V| with sign and overflow.
// Optional macro SD2_OVF_SAT_EN: overflowing frames saturate to all-01 digits instead of emitting 00 from the detecting digit on.
module sd2_ovf_serial #(
    parameter int NDIG = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_digit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_digit,
    output logic       out_last,
    output logic [1:0] sign_out,
    output logic       wrong
);

    localparam int CW = $clog2(NDIG + 1);

`ifdef SD2_OVF_SAT_EN
    localparam logic [1:0] OVF_DIGIT = 2'b01;
`else
    localparam logic [1:0] OVF_DIGIT = 2'b00;
`endif

    typedef enum logic [2:0] {
        FLAG,
        PEND,
        BORROW,
        PASS,
        OVF
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_s;
    logic            r_outValid;
    logic [1:0]      r_outDigit;
    logic            r_outLast;
    logic [1:0]      r_signOut;
    logic            r_wrong;

    logic            w_inReady;
    logic            w_inFire;
    logic            w_isZero;
    logic [1:0]      w_dNorm;
    logic [1:0]      w_negS;
    logic            w_lastDigit;
    logic [1:0]      w_emitDigit;
    logic [1:0]      w_sNext;
    logic            w_ovfNow;

    assign w_inReady   = ~r_outValid | out_ready;
    assign w_inFire    = in_valid & w_inReady;
    assign w_isZero    = (in_digit == 2'b00);
    // Both 01 and 10 mean +1; collapse to 01 so comparisons and output encoding stay canonical.
    assign w_dNorm     = w_isZero ? 2'b00 : ((in_digit == 2'b11) ? 2'b11 : 2'b01);
    assign w_negS      = (r_s == 2'b01) ? 2'b11 : 2'b01;
    assign w_lastDigit = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FLAG;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_inFire) begin
            case (r_state)
                FLAG: begin
                    w_nextState = w_isZero ? PEND : BORROW;
                end
                PEND: begin
                    if (!w_isZero) begin
                        w_nextState = PASS;
                    end
                end
                BORROW: begin
                    if (w_dNorm == w_negS) begin
                        w_nextState = PASS;
                    end else if (w_dNorm == r_s) begin
                        w_nextState = OVF;
                    end
                end
                default: begin
                    w_nextState = r_state;
                end
            endcase
            if ((r_state != FLAG) && w_lastDigit) begin
                w_nextState = FLAG;
            end
        end
    end

    always_comb begin
        w_emitDigit = 2'b00;
        w_sNext     = r_s;
        w_ovfNow    = 1'b0;
        case (r_state)
            FLAG: begin
                w_sNext = w_dNorm;
            end
            PEND: begin
                if (!w_isZero) begin
                    w_sNext     = w_dNorm;
                    w_emitDigit = 2'b01;
                end
            end
            BORROW: begin
                // A zero tail leaves |V| = 2^NDIG exactly, which is still out of range.
                if ((w_isZero && w_lastDigit) || (w_dNorm == r_s)) begin
                    w_ovfNow    = 1'b1;
                    w_emitDigit = OVF_DIGIT;
                end else begin
                    w_emitDigit = 2'b01;
                end
            end
            PASS: begin
                if (r_s == 2'b11) begin
                    w_emitDigit = (w_dNorm == 2'b01) ? 2'b11 :
                                  ((w_dNorm == 2'b11) ? 2'b01 : 2'b00);
                end else begin
                    w_emitDigit = w_dNorm;
                end
            end
            OVF: begin
                w_emitDigit = OVF_DIGIT;
            end
            default: begin
                w_emitDigit = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_s        <= 2'b00;
            r_outValid <= 1'b0;
            r_outDigit <= 2'b00;
            r_outLast  <= 1'b0;
            r_signOut  <= 2'b00;
            r_wrong    <= 1'b0;
        end else begin
            if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            if (w_inFire) begin
                r_s <= w_sNext;
                if (r_state == FLAG) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt      <= w_lastDigit ? '0 : r_cnt + CW'(1);
                    r_outValid <= 1'b1;
                    r_outDigit <= w_emitDigit;
                    r_outLast  <= w_lastDigit;
                    r_signOut  <= w_sNext;
                    r_wrong    <= (r_cnt == '0) ? w_ovfNow : (r_wrong | w_ovfNow);
                end
            end
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign out_digit = r_outDigit;
    assign out_last  = r_outLast;
    assign sign_out  = r_signOut;
    assign wrong     = r_wrong;

endmodule

// File: tb/tb_sd2_ovf_serial.sv
// Bench for sd2_ovf_serial (NDIG=4): directed frames, backpressure, reset abort and random frames against an arithmetic model.
module tb_sd2_ovf_serial;

    localparam int N = 4;

    typedef struct {
        int             expVal;
        bit             expWrong;
        logic [1:0]     expSign;
        bit             hasExact;
        logic [2*N-1:0] exact;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_digit;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_digit;
    logic       out_last;
    logic [1:0] sign_out;
    logic       wrong;

    logic       randomReady;
    logic       manualReady;
    logic       rndReady;

    int         checks = 0;
    int         errors = 0;
    frame_t     expQ[$];

    int             beatIdx = 0;
    int             streamVal = 0;
    logic [2*N-1:0] seen;
    frame_t         monFrame;

    sd2_ovf_serial #(.NDIG(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_last  (out_last),
        .sign_out  (sign_out),
        .wrong     (wrong)
    );

    always #5 clk = ~clk;

    assign out_ready = randomReady ? rndReady : manualReady;

    initial begin
        rndReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rndReady = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int digVal(input logic [1:0] d);
        if (d == 2'b00) return 0;
        if (d == 2'b11) return -1;
        return 1;
    endfunction

    // Reference: evaluate V numerically, then derive the magnitude stream value the frame should carry.
    function automatic frame_t modelFrame(input logic [1:0] f, input logic [2*N-1:0] dig);
        frame_t fr;
        int w = 0;
        int v;
        int mag;
        int p = -1;
        for (int i = N - 1; i >= 0; i--) begin
            w = w * 2 + digVal(dig[2*i +: 2]);
            if (p < 0 && digVal(dig[2*i +: 2]) != 0) p = i;
        end
        v   = digVal(f) * (1 << N) + w;
        mag = (v < 0) ? -v : v;
        fr.expWrong = (mag >= (1 << N));
        fr.expSign  = (v > 0) ? 2'b01 : ((v < 0) ? 2'b11 : 2'b00);
        if (!fr.expWrong) begin
            fr.expVal = mag;
        end else begin
`ifdef SD2_OVF_SAT_EN
            fr.expVal = (1 << N) - 1;
`else
            fr.expVal = (p < 0) ? (1 << N) - 2 : (1 << N) - (1 << (p + 1));
`endif
        end
        fr.hasExact = 1'b0;
        fr.exact    = '0;
        return fr;
    endfunction

    task automatic sendDigit(input logic [1:0] d, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_digit = d;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checkOutput("inReadyTimeout", in_ready, 1);
            $fatal(1, "[TB] input stalled too long");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] f, input logic [2*N-1:0] dig, input int gapMax,
                                 input bit hasExact, input logic [2*N-1:0] exact, output int totalWaits);
        frame_t fr;
        int w;
        fr = modelFrame(f, dig);
        fr.hasExact = hasExact;
        fr.exact    = exact;
        expQ.push_back(fr);
        totalWaits = 0;
        sendDigit(f, w);
        totalWaits += w;
        for (int i = N - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, gapMax)) begin
                @(posedge clk);
                #1;
            end
            sendDigit(dig[2*i +: 2], w);
            totalWaits += w;
        end
    endtask

    // Monitor: rebuild each output frame and compare it with the oldest expected frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            beatIdx   = 0;
            streamVal = 0;
        end else if (out_valid && out_ready) begin
            checkOutput("digitCode", (out_digit != 2'b10), 1);
            checkOutput("lastFlag", out_last, (beatIdx == N - 1));
            streamVal = streamVal * 2 + digVal(out_digit);
            seen[2*(N-1-beatIdx) +: 2] = out_digit;
            beatIdx++;
            if (out_last || beatIdx == N) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFrame", expQ.size(), 1);
                end else begin
                    monFrame = expQ.pop_front();
                    checkOutput("magnitude", streamVal, monFrame.expVal);
                    checkOutput("wrong", wrong, monFrame.expWrong);
                    checkOutput("sign", sign_out, monFrame.expSign);
                    if (monFrame.hasExact) begin
                        checkOutput("exactDigits", seen, monFrame.exact);
                    end
                end
                beatIdx   = 0;
                streamVal = 0;
            end
        end
    end

    initial begin
        int w;
        int cyc;
        logic [1:0] held;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_digit    = 2'b00;
        manualReady = 1'b1;
        randomReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstOutDigit", out_digit, 0);
        checkOutput("rstOutLast", out_last, 0);
        checkOutput("rstSign", sign_out, 0);
        checkOutput("rstWrong", wrong, 0);
        checkOutput("rstInReady", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] directed frames");
        applyStimulus(2'b00, 8'b00_00_11_01, 1, 1'b1, 8'b00_00_01_11, w);
        applyStimulus(2'b01, 8'b00_11_00_01, 1, 1'b1, 8'b01_01_00_01, w);
        applyStimulus(2'b01, 8'b00_11_00_10, 0, 1'b1, 8'b01_01_00_01, w);
`ifdef SD2_OVF_SAT_EN
        applyStimulus(2'b01, 8'b00_01_00_00, 0, 1'b1, 8'b01_01_01_01, w);
        applyStimulus(2'b11, 8'b00_00_00_00, 0, 1'b1, 8'b01_01_01_01, w);
`else
        applyStimulus(2'b01, 8'b00_01_00_00, 0, 1'b1, 8'b01_00_00_00, w);
        applyStimulus(2'b11, 8'b00_00_00_00, 0, 1'b1, 8'b01_01_01_00, w);
`endif
        applyStimulus(2'b00, 8'b00_00_00_00, 0, 1'b1, 8'b00_00_00_00, w);

        $display("[TB] backpressure");
        begin
            frame_t fr;
            fr = modelFrame(2'b01, 8'b00_11_00_01);
            fr.hasExact = 1'b1;
            fr.exact    = 8'b01_01_00_01;
            expQ.push_back(fr);
        end
        sendDigit(2'b01, w);
        sendDigit(2'b00, w);
        sendDigit(2'b11, w);
        manualReady = 1'b0;
        in_valid    = 1'b1;
        in_digit    = 2'b00;
        held        = out_digit;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stallInReady", in_ready, 0);
            checkOutput("stallOutValid", out_valid, 1);
            checkOutput("stallHold", out_digit, held);
            @(posedge clk);
            #1;
        end
        manualReady = 1'b1;
        sendDigit(2'b00, w);
        sendDigit(2'b01, w);

        $display("[TB] back-to-back frames");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'($urandom), 8'($urandom), 0, 1'b0, 8'h00, w);
            checkOutput("fullRate", w, 0);
        end

        $display("[TB] reset mid-frame");
        sendDigit(2'b01, w);
        sendDigit(2'b00, w);
        sendDigit(2'b11, w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abortOutValid", out_valid, 0);
        checkOutput("abortWrong", wrong, 0);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 8'b00_00_00_00, 0, 1'b1, 8'b00_00_00_00, w);

        $display("[TB] random frames");
        randomReady = 1'b1;
        for (int k = 0; k < 150; k++) begin
            applyStimulus(2'($urandom), 8'($urandom), 2, 1'b0, 8'h00, w);
        end

        cyc = 0;
        while (expQ.size() != 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("drain", expQ.size(), 0);
        checkOutput("partialBeats", beatIdx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
